// File: rtl/sig_compactor_pkg.sv
// Shared types and helpers for the output signature compactor.
package sig_compactor_pkg;

   // Helper functions work on fixed maximum widths. Callers zero-extend
   // their operands and truncate the result back to their own width.
   localparam int MAX_W  = 64;
   localparam int MAX_IN = 16;
   localparam int MAX_D  = MAX_W * MAX_IN;

   typedef enum logic {IDLE, SEND} state_t;

   // One Galois MISR shift. Bits at and above 'width' in the result are
   // don't-care; the caller keeps only the low 'width' bits.
   function automatic logic [MAX_W-1:0] misr_step(input logic [MAX_W-1:0] m,
                                                  input logic [MAX_W-1:0] poly,
                                                  input int width);
      logic             msb;
      logic [MAX_W-1:0] r;
      msb = |((m >> (width - 1)) & MAX_W'(1));
      r   = m << 1;
      if (msb) r = r ^ poly;
      return r;
   endfunction

   // XOR of the first num_in words of 'width' bits each. The low 'width'
   // bits of the result are the fold; anything above is don't-care.
   function automatic logic [MAX_W-1:0] fold_words(input logic [MAX_D-1:0] data,
                                                   input int num_in,
                                                   input int width);
      logic [MAX_W-1:0] acc;
      acc = '0;
      for (int k = 0; k < MAX_IN; k++)
         if (k < num_in) acc = acc ^ MAX_W'(data >> (k * width));
      return acc;
   endfunction

endpackage

// File: rtl/misr_core.sv
// MISR register: folds one word per enabled cycle and reloads the seed
// at each window boundary.
module misr_core
   import sig_compactor_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] POLY  = 32'h04C11DB7,
   parameter logic [WIDTH-1:0] SEED  = 32'hFFFFFFFF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] fold_i,
   output logic [WIDTH-1:0] misr_nxt_o
);

   logic [WIDTH-1:0] misr_q, misr_d;

   assign misr_nxt_o = WIDTH'(misr_step(MAX_W'(misr_q), MAX_W'(POLY), WIDTH)) ^ fold_i;

   // Clear wins over advance so a window-end cycle restarts from the seed.
   always_comb begin
      misr_d = misr_q;
      if (en_i) misr_d = clr_i ? SEED : misr_nxt_o;
   end

   // MISR state register.
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) misr_q <= SEED;
      else         misr_q <= misr_d;

endmodule

// File: rtl/output_signature_compactor.sv
// Compacts wide observed outputs into a MISR signature per window and
// streams each signature LSB slice first over a narrow valid/ready port.
module output_signature_compactor
   import sig_compactor_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter int               NUM_IN = 8,
   parameter int               WINDOW = 1024,
   parameter int               OUT_W  = 8,
   parameter logic [WIDTH-1:0] POLY   = 32'h04C11DB7,
   parameter logic [WIDTH-1:0] SEED   = 32'hFFFFFFFF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic                    in_valid,
   output logic [OUT_W-1:0]        sig_out,
   output logic                    sig_valid,
   input  logic                    sig_ready,
   output logic                    sig_last,
   output logic                    overrun
);

   localparam int BEATS  = WIDTH / OUT_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CNT_W  = $clog2(WINDOW);

   logic [CNT_W-1:0]  win_cnt_q;
   logic [WIDTH-1:0]  fold, snap;
   logic              win_end, retire, last_ret;

   state_t            state_q;
   logic [WIDTH-1:0]  shift_q;
   logic [BEAT_W-1:0] beat_q;
   logic              sig_valid_q, sig_last_q, overrun_q;

   // NUM_IN*WIDTH must fit in MAX_D bits of the fold helper.
   assign fold     = WIDTH'(fold_words(MAX_D'(in_data), NUM_IN, WIDTH));
   assign win_end  = in_valid && (win_cnt_q == CNT_W'(WINDOW - 1));
   assign retire   = sig_valid_q && sig_ready;
   assign last_ret = retire && sig_last_q;

   misr_core #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_misr (
      .clk_i      (clk),
      .rst_ni     (reset),
      .en_i       (in_valid),
      .clr_i      (win_end),
      .fold_i     (fold),
      .misr_nxt_o (snap)
   );

   // Window counter advances only on compacted cycles.
   always_ff @(posedge clk or negedge reset)
      if (!reset)        win_cnt_q <= '0;
      else if (win_end)  win_cnt_q <= '0;
      else if (in_valid) win_cnt_q <= win_cnt_q + CNT_W'(1);

   // Serializer: takes a snapshot when free or when the last beat retires
   // in the same cycle, otherwise drops it and flags overrun.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         beat_q      <= '0;
         sig_valid_q <= 1'b0;
         sig_last_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (win_end) begin
               state_q     <= SEND;
               shift_q     <= snap;
               beat_q      <= '0;
               sig_valid_q <= 1'b1;
               sig_last_q  <= (BEATS == 1);
            end
            SEND: begin
               if (win_end && !last_ret) overrun_q <= 1'b1;
               if (win_end && last_ret) begin
                  shift_q    <= snap;
                  beat_q     <= '0;
                  sig_last_q <= (BEATS == 1);
               end else if (last_ret) begin
                  state_q     <= IDLE;
                  shift_q     <= '0;
                  beat_q      <= '0;
                  sig_valid_q <= 1'b0;
                  sig_last_q  <= 1'b0;
               end else if (retire) begin
                  shift_q    <= shift_q >> OUT_W;
                  beat_q     <= beat_q + BEAT_W'(1);
                  sig_last_q <= (beat_q == BEAT_W'(BEATS - 2));
               end
            end
            default: state_q <= IDLE;
         endcase
      end

   assign sig_out   = shift_q[OUT_W-1:0];
   assign sig_valid = sig_valid_q;
   assign sig_last  = sig_last_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_output_signature_compactor.sv
// Scoreboard bench: WINDOW=4 instance against a reference model, plus a
// WINDOW=2 instance for back-to-back signatures.
module tb_output_signature_compactor;

   typedef struct {
      logic [3:0] beat;
      bit         last;
   } beat_t;

   logic        clk, reset;
   logic [15:0] in_data, d2_data;
   logic        in_valid, sig_ready, d2_valid, d2_ready;
   logic [3:0]  sig_out, d2_out;
   logic        sig_valid, sig_last, overrun, d2_svalid, d2_last, d2_ovr;

   int          n_chk = 0, n_err = 0;
   logic [7:0]  m_misr;
   int          m_cnt, m_rem;
   bit          m_ovr;
   beat_t       exp_q[$];
   logic [3:0]  obs_q[$];

   output_signature_compactor #(.WIDTH(8), .NUM_IN(2), .WINDOW(4), .OUT_W(4),
      .POLY(8'h1D), .SEED(8'hFF)) u_dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .sig_out(sig_out), .sig_valid(sig_valid), .sig_ready(sig_ready),
      .sig_last(sig_last), .overrun(overrun));

   output_signature_compactor #(.WIDTH(8), .NUM_IN(2), .WINDOW(2), .OUT_W(4),
      .POLY(8'h1D), .SEED(8'hFF)) u_dut2 (
      .clk(clk), .reset(reset), .in_data(d2_data), .in_valid(d2_valid),
      .sig_out(d2_out), .sig_valid(d2_svalid), .sig_ready(d2_ready),
      .sig_last(d2_last), .overrun(d2_ovr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] m_step(input logic [7:0] m);
      return {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00);
   endfunction

   task automatic m_reset();
      m_misr = 8'hFF;
      m_cnt  = 0;
      m_rem  = 0;
      m_ovr  = 1'b0;
      exp_q.delete();
   endtask

   // Called at a negedge: check outputs against the model, drive the next
   // inputs, advance the model across the coming posedge.
   task automatic step(input bit v, input logic [15:0] d, input bit r);
      logic [7:0] nxt;
      bit         snap;
      chk("valid", 32'(sig_valid), 32'(m_rem > 0));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (m_rem > 0) begin
         chk("beat", 32'(sig_out), 32'(exp_q[0].beat));
         chk("last", 32'(sig_last), 32'(exp_q[0].last));
      end else begin
         chk("idle_out", 32'(sig_out), 32'h0);
         chk("idle_last", 32'(sig_last), 32'h0);
      end
      in_valid  = v;
      in_data   = d;
      sig_ready = r;
      snap      = 1'b0;
      nxt       = 8'h00;
      if (m_rem > 0 && r) begin
         obs_q.push_back(sig_out);
         void'(exp_q.pop_front());
         m_rem--;
      end
      if (v) begin
         nxt = m_step(m_misr) ^ d[7:0] ^ d[15:8];
         if (m_cnt == 3) begin
            snap   = 1'b1;
            m_misr = 8'hFF;
            m_cnt  = 0;
         end else begin
            m_misr = nxt;
            m_cnt++;
         end
      end
      if (snap) begin
         if (m_rem == 0) begin
            exp_q.push_back('{beat: nxt[3:0], last: 1'b0});
            exp_q.push_back('{beat: nxt[7:4], last: 1'b1});
            m_rem = 2;
         end else m_ovr = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_sig(input string tag, input logic [3:0] b0, input logic [3:0] b1);
      chk({tag, "_n"}, 32'(obs_q.size()), 32'd2);
      chk({tag, "_b0"}, 32'(obs_q[0]), 32'(b0));
      chk({tag, "_b1"}, 32'(obs_q[1]), 32'(b1));
      obs_q.delete();
   endtask

   initial begin
      reset = 1'b0; in_data = '0; in_valid = 1'b0; sig_ready = 1'b1;
      d2_data = '0; d2_valid = 1'b0; d2_ready = 1'b1;
      m_reset();
      #1;
      chk("rst_valid", 32'(sig_valid), 32'h0);
      chk("rst_out", 32'(sig_out), 32'h0);
      chk("rst_last", 32'(sig_last), 32'h0);
      chk("rst_ovr", 32'(overrun), 32'h0);
      chk("rst2_valid", 32'(d2_svalid), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // 1: four zero words -> 4B, beats B then 4
      obs_q.delete();
      repeat (4) step(1, 16'h0, 1);
      repeat (4) step(0, 16'h0, 1);
      chk_sig("t1", 4'hB, 4'h4);

      // 2: gaps do not disturb the signature; nonzero fold changes it
      repeat (4) begin step(1, 16'h0, 1); step(0, 16'h0, 1); end
      repeat (4) step(0, 16'h0, 1);
      chk_sig("t2_gap", 4'hB, 4'h4);
      step(1, 16'h5AA5, 1);
      repeat (3) step(1, 16'h0, 1);
      repeat (4) step(0, 16'h0, 1);
      chk_sig("t2_data", 4'h0, 4'hE);

      // 3: sink stalled across two windows -> second dropped
      repeat (8) step(1, 16'h0, 0);
      chk("t3_ovr", 32'(overrun), 32'h1);
      chk("t3_hold", 32'(sig_out), 32'hB);
      repeat (6) step(0, 16'h0, 1);
      chk_sig("t3", 4'hB, 4'h4);

      // 4: async reset after the first beat retires
      repeat (4) step(1, 16'h0, 1);
      step(0, 16'h0, 1);
      chk("t4_pre_last", 32'(sig_last), 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("t4_valid", 32'(sig_valid), 32'h0);
      chk("t4_out", 32'(sig_out), 32'h0);
      chk("t4_last", 32'(sig_last), 32'h0);
      chk("t4_ovr", 32'(overrun), 32'h0);
      m_reset();
      obs_q.delete();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      repeat (4) step(1, 16'h0, 1);
      repeat (4) step(0, 16'h0, 1);
      chk_sig("t4", 4'hB, 4'h4);

      // 5: WINDOW=2, continuous zeros -> DB back to back, no drops
      d2_valid = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k >= 2) begin
            chk("t5_valid", 32'(d2_svalid), 32'h1);
            chk("t5_beat", 32'(d2_out), (k % 2 == 0) ? 32'hB : 32'hD);
            chk("t5_last", 32'(d2_last), 32'(k % 2));
            chk("t5_ovr", 32'(d2_ovr), 32'h0);
         end
      end
      d2_valid = 1'b0;

      // 6: random traffic against the model
      for (int i = 0; i < 10000; i++)
         step(1'($urandom_range(0, 1)), 16'($urandom),
              $urandom_range(0, 9) < ((i < 5000) ? 8 : 3));
      repeat (10) step(0, 16'h0, 1);
      chk("t6_drain", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
